// File: rtl/alu_seq_param.sv
// Handshaked WIDTH-bit ALU with registered result/flags and 1-bit/cycle shifter.
// Optional macro ALU_SLT_EN enables op 8 (signed slt) and op 9 (unsigned slt).
module alu_seq_param #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             illegal
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int MSB = WIDTH - 1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh_q;
    logic [SHW-1:0]   cnt_q;
    logic             sra_q;

    logic             accept;
    logic             shift_nz;
    logic             last_shift;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] c_res;
    logic             c_carry;
    logic             c_ovf;
    logic             c_ill;
    logic [WIDTH-1:0] sh_nx;
    logic             sh_out;

    assign amt        = b[SHW-1:0];
    assign accept     = in_valid && in_ready;
    assign shift_nz   = (op == 4'd5 || op == 4'd6) && (amt != '0);
    assign last_shift = (state == SHIFT) && (cnt_q == SHW'(1));

    // Single-cycle ops; shifts by zero pass A through with carry clear
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        dif     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        c_res   = '0;
        c_carry = 1'b0;
        c_ovf   = 1'b0;
        c_ill   = 1'b0;
        case (op)
            4'd0: c_res = a & b;
            4'd1: c_res = a | b;
            4'd2: begin
                c_res   = sum[MSB:0];
                c_carry = sum[WIDTH];
                c_ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            4'd3: c_res = a ^ b;
            4'd4: begin
                c_res   = dif[MSB:0];
                c_carry = dif[WIDTH];
                c_ovf   = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
            end
            4'd5: c_res = a;
            4'd6: c_res = a;
            4'd7: c_res = ~(a | b);
`ifdef ALU_SLT_EN
            4'd8: c_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'd9: c_res = {{(WIDTH-1){1'b0}}, a < b};
`endif
            default: c_ill = 1'b1;
        endcase
    end

    // One-bit shift step and the bit it pushes out
    always_comb begin
        sh_nx  = sra_q ? {sh_q[MSB], sh_q[MSB:1]} : {sh_q[MSB-1:0], 1'b0};
        sh_out = sra_q ? sh_q[0] : sh_q[MSB];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; DONE can accept back-to-back when out_ready is high
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) state_nx = shift_nz ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt_q == SHW'(1)) state_nx = DONE;
            end
            DONE: begin
                if (accept)         state_nx = shift_nz ? SHIFT : DONE;
                else if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    // Datapath: load shifter or capture single-cycle result; finish shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            sra_q    <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            illegal  <= 1'b0;
        end else if (accept) begin
            if (shift_nz) begin
                sh_q  <= a;
                cnt_q <= amt;
                sra_q <= (op == 4'd5);
            end else begin
                result   <= c_res;
                zero     <= (c_res == '0);
                carry    <= c_carry;
                overflow <= c_ovf;
                negative <= c_res[MSB];
                illegal  <= c_ill;
            end
        end else if (state == SHIFT) begin
            sh_q  <= sh_nx;
            cnt_q <= cnt_q - SHW'(1);
            if (last_shift) begin
                result   <= sh_nx;
                zero     <= (sh_nx == '0);
                carry    <= sh_out;
                overflow <= 1'b0;
                negative <= sh_nx[MSB];
                illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed testbench for alu_seq_param at WIDTH=32.
// Expected values are hand-computed constants.
module tb_alu_seq_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        negative;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int rdy_lo;

    alu_seq_param #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge; sample is #1 after that edge
    task automatic issue(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count cycles from accept until out_valid, bounded
    task automatic wait_done(output int c, output int lo);
        c  = 1;
        lo = 0;
        while (!out_valid && c < 100) begin
            if (!in_ready) lo++;
            tick();
            c++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 4'd0;
        a         = '0;
        b         = '0;
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        issue(4'd2, 32'h7FFF_FFFF, 32'd1);
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_result", result, 32'h8000_0000);
        chk("add_ovf", {31'b0, overflow}, 32'd1);
        chk("add_neg", {31'b0, negative}, 32'd1);
        chk("add_carry", {31'b0, carry}, 32'd0);
        chk("add_zero", {31'b0, zero}, 32'd0);

        issue(4'd4, 32'd5, 32'd5);
        chk("sub_eq_result", result, 32'd0);
        chk("sub_eq_zero", {31'b0, zero}, 32'd1);
        chk("sub_eq_carry", {31'b0, carry}, 32'd1);
        chk("sub_eq_ovf", {31'b0, overflow}, 32'd0);

        issue(4'd4, 32'd3, 32'd5);
        chk("sub_lt_result", result, 32'hFFFF_FFFE);
        chk("sub_lt_carry", {31'b0, carry}, 32'd0);
        chk("sub_lt_neg", {31'b0, negative}, 32'd1);

        issue(4'd6, 32'd1, 32'd31);
        wait_done(cyc, rdy_lo);
        chk("sll31_latency", cyc, 32'd32);
        chk("sll31_busy", rdy_lo, 32'd31);
        chk("sll31_result", result, 32'h8000_0000);
        chk("sll31_carry", {31'b0, carry}, 32'd0);

        issue(4'd5, 32'h8000_0001, 32'd4);
        wait_done(cyc, rdy_lo);
        chk("sra4_latency", cyc, 32'd5);
        chk("sra4_result", result, 32'hF800_0000);
        chk("sra4_carry", {31'b0, carry}, 32'd0);

        issue(4'd5, 32'h0000_0006, 32'h0000_0022);
        wait_done(cyc, rdy_lo);
        chk("sra_mod_latency", cyc, 32'd3);
        chk("sra_mod_result", result, 32'h0000_0001);
        chk("sra_mod_carry", {31'b0, carry}, 32'd1);

        issue(4'd6, 32'd1, 32'd0);
        chk("sll0_valid", {31'b0, out_valid}, 32'd1);
        chk("sll0_result", result, 32'd1);
        chk("sll0_carry", {31'b0, carry}, 32'd0);

        tick();
        chk("idle_after_done", {31'b0, out_valid}, 32'd0);

        out_ready = 1'b0;
        issue(4'd3, 32'h12, 32'h30);
        chk("bp_first", result, 32'h22);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_result", result, 32'h22);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_ready", {31'b0, in_ready}, 32'd1);
        issue(4'd0, 32'hF0, 32'h0F);
        chk("b2b_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b_result", result, 32'd0);
        chk("b2b_zero", {31'b0, zero}, 32'd1);

        issue(4'd12, 32'd5, 32'd3);
        chk("ill12_flag", {31'b0, illegal}, 32'd1);
        chk("ill12_result", result, 32'd0);
        chk("ill12_zero", {31'b0, zero}, 32'd1);
        chk("ill12_carry", {31'b0, carry}, 32'd0);

        issue(4'd8, 32'hFFFF_FFFF, 32'd1);
`ifdef ALU_SLT_EN
        chk("slt_s_result", result, 32'd1);
        chk("slt_s_illegal", {31'b0, illegal}, 32'd0);
        issue(4'd9, 32'hFFFF_FFFF, 32'd1);
        chk("slt_u_result", result, 32'd0);
        chk("slt_u_illegal", {31'b0, illegal}, 32'd0);
`else
        chk("ill8_flag", {31'b0, illegal}, 32'd1);
        chk("ill8_result", result, 32'd0);
`endif

        issue(4'd7, 32'hFFFF_0000, 32'h0000_00FF);
        chk("nor_result", result, 32'h0000_FF00);
        chk("nor_illegal", {31'b0, illegal}, 32'd0);

        issue(4'd2, 32'd2, 32'd2);
        chk("pre_rst_result", result, 32'd4);
        issue(4'd6, 32'd3, 32'd20);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_shift_busy", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
        issue(4'd2, 32'd2, 32'd3);
        chk("post_rst_add", result, 32'd5);
        chk("post_rst_valid", {31'b0, out_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
